// File: rtl/match_sequencer.sv
// Round/match sequencer for a two-player fighting game: pre-round countdown,
// fight timer, KO freeze, best-of-N scoring and hold-to-restart after the match.
module match_sequencer #(
  parameter int TICKS_PER_SEC = 20,
  parameter int CD_TICKS      = 20,
  parameter int KO_TICKS      = 40,
  parameter int HOLD_TICKS    = 40,
  parameter int ROUND_SECS    = 99,
  parameter int MAX_ROUNDS    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_btn,
  input  logic [1:0] winner,
  output logic       round_reset,
  output logic       freeze,
  output logic [2:0] state,
  output logic [1:0] round_no,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic [1:0] countdown,
  output logic [6:0] time_left,
  output logic       match_over,
  output logic [1:0] match_winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_COUNTDOWN  = 3'd1,
    S_FIGHT      = 3'd2,
    S_KO         = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  localparam logic [5:0] SEC_LAST   = 6'(TICKS_PER_SEC - 1);
  localparam logic [5:0] CD_LAST    = 6'(CD_TICKS - 1);
  localparam logic [5:0] KO_LAST    = 6'(KO_TICKS - 1);
  localparam logic [5:0] HOLD_LAST  = 6'(HOLD_TICKS - 1);
  localparam logic [6:0] SECS_INIT  = 7'(ROUND_SECS);
  localparam logic [1:0] WIN_ROUNDS = 2'((MAX_ROUNDS + 1) / 2);
  localparam logic [1:0] LAST_ROUND = 2'(MAX_ROUNDS);

  state_t     r_state,  w_state_nxt;
  logic [5:0] r_sub,    w_sub_nxt;
  logic [1:0] r_round,  w_round_nxt;
  logic [1:0] r_p1,     w_p1_nxt;
  logic [1:0] r_p2,     w_p2_nxt;
  logic [1:0] r_cd,     w_cd_nxt;
  logic [6:0] r_time,   w_time_nxt;
  logic [1:0] r_result, w_result_nxt;
  logic       r_over,   w_over_nxt;
  logic [1:0] r_mwin,   w_mwin_nxt;
  logic       r_round_reset, w_round_reset_nxt;
  logic       r_freeze, w_freeze_nxt;
  logic [1:0] w_p1_award, w_p2_award;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_sub_nxt         = r_sub;
    w_round_nxt       = r_round;
    w_p1_nxt          = r_p1;
    w_p2_nxt          = r_p2;
    w_cd_nxt          = r_cd;
    w_time_nxt        = r_time;
    w_result_nxt      = r_result;
    w_over_nxt        = r_over;
    w_mwin_nxt        = r_mwin;
    w_round_reset_nxt = 1'b0;
    w_p1_award        = r_p1;
    w_p2_award        = r_p2;

    if (tick) begin
      case (r_state)
        S_IDLE: begin
          if (start_btn) begin
            w_state_nxt       = S_COUNTDOWN;
            w_round_nxt       = 2'd1;
            w_p1_nxt          = 2'd0;
            w_p2_nxt          = 2'd0;
            w_cd_nxt          = 2'd3;
            w_round_reset_nxt = 1'b1;
          end
        end
        S_COUNTDOWN: begin
          if (r_sub == CD_LAST) begin
            w_sub_nxt = 6'd0;
            if (r_cd == 2'd1) begin
              w_state_nxt = S_FIGHT;
              w_cd_nxt    = 2'd0;
              w_time_nxt  = SECS_INIT;
            end else begin
              w_cd_nxt = r_cd - 2'd1;
            end
          end else begin
            w_sub_nxt = r_sub + 6'd1;
          end
        end
        S_FIGHT: begin
          if (r_sub == SEC_LAST) begin
            w_sub_nxt = 6'd0;
            if (r_time != 7'd0) w_time_nxt = r_time - 7'd1;
          end else begin
            w_sub_nxt = r_sub + 6'd1;
          end
          // A reported winner outranks a timeout landing on the same tick.
          if (winner != 2'b00) begin
            w_state_nxt  = S_KO;
            w_result_nxt = winner;
          end else if (w_time_nxt == 7'd0) begin
            w_state_nxt  = S_KO;
            w_result_nxt = 2'b11;
          end
        end
        S_KO: begin
          if (r_sub == KO_LAST) begin
            if (r_result == 2'b01 && r_p1 != LAST_ROUND) w_p1_award = r_p1 + 2'd1;
            if (r_result == 2'b10 && r_p2 != LAST_ROUND) w_p2_award = r_p2 + 2'd1;
            w_p1_nxt = w_p1_award;
            w_p2_nxt = w_p2_award;
            if (w_p1_award == WIN_ROUNDS || w_p2_award == WIN_ROUNDS || r_round == LAST_ROUND) begin
              w_state_nxt = S_MATCH_OVER;
              w_over_nxt  = 1'b1;
              if (w_p1_award > w_p2_award)      w_mwin_nxt = 2'b01;
              else if (w_p2_award > w_p1_award) w_mwin_nxt = 2'b10;
              else                              w_mwin_nxt = 2'b11;
            end else begin
              w_state_nxt       = S_COUNTDOWN;
              w_round_nxt       = r_round + 2'd1;
              w_cd_nxt          = 2'd3;
              w_round_reset_nxt = 1'b1;
            end
          end else begin
            w_sub_nxt = r_sub + 6'd1;
          end
        end
        S_MATCH_OVER: begin
          // The sub-counter doubles as the start_btn hold counter here.
          if (!start_btn) begin
            w_sub_nxt = 6'd0;
          end else if (r_sub == HOLD_LAST) begin
            w_state_nxt       = S_COUNTDOWN;
            w_round_nxt       = 2'd1;
            w_p1_nxt          = 2'd0;
            w_p2_nxt          = 2'd0;
            w_cd_nxt          = 2'd3;
            w_over_nxt        = 1'b0;
            w_mwin_nxt        = 2'b00;
            w_round_reset_nxt = 1'b1;
          end else begin
            w_sub_nxt = r_sub + 6'd1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_state_nxt != r_state) w_sub_nxt = 6'd0;
    end

    w_freeze_nxt = (w_state_nxt != S_FIGHT);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_sub         <= 6'd0;
      r_round       <= 2'd0;
      r_p1          <= 2'd0;
      r_p2          <= 2'd0;
      r_cd          <= 2'd0;
      r_time        <= 7'd0;
      r_result      <= 2'b00;
      r_over        <= 1'b0;
      r_mwin        <= 2'b00;
      r_round_reset <= 1'b0;
      r_freeze      <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_sub         <= w_sub_nxt;
      r_round       <= w_round_nxt;
      r_p1          <= w_p1_nxt;
      r_p2          <= w_p2_nxt;
      r_cd          <= w_cd_nxt;
      r_time        <= w_time_nxt;
      r_result      <= w_result_nxt;
      r_over        <= w_over_nxt;
      r_mwin        <= w_mwin_nxt;
      r_round_reset <= w_round_reset_nxt;
      r_freeze      <= w_freeze_nxt;
    end
  end

  assign state        = r_state;
  assign round_reset  = r_round_reset;
  assign freeze       = r_freeze;
  assign round_no     = r_round;
  assign p1_rounds    = r_p1;
  assign p2_rounds    = r_p2;
  assign countdown    = r_cd;
  assign time_left    = r_time;
  assign match_over   = r_over;
  assign match_winner = r_mwin;

endmodule

// File: tb/tb_match_sequencer.sv
// Self-checking bench for match_sequencer: directed match scenarios with randomized
// tick spacing, ignored-input noise and round outcomes, scored by a match-level model.
module tb_match_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start_btn;
  logic [1:0] winner;
  logic       round_reset;
  logic       freeze;
  logic [2:0] state;
  logic [1:0] round_no;
  logic [1:0] p1_rounds;
  logic [1:0] p2_rounds;
  logic [1:0] countdown;
  logic [6:0] time_left;
  logic       match_over;
  logic [1:0] match_winner;

  match_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .start_btn    (start_btn),
    .winner       (winner),
    .round_reset  (round_reset),
    .freeze       (freeze),
    .state        (state),
    .round_no     (round_no),
    .p1_rounds    (p1_rounds),
    .p2_rounds    (p2_rounds),
    .countdown    (countdown),
    .time_left    (time_left),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int rr_cycles = 0;
  int rr_exp    = 0;

  // Match-level reference: scores, round index, last round result, match finished.
  int         m_p1, m_p2, m_round;
  logic [1:0] m_res;
  bit         m_over;

  always @(negedge clk) if (round_reset === 1'b1) rr_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick_once(input logic st, input logic [1:0] w);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) @(negedge clk);
    start_btn = st;
    winner    = w;
    tick      = 1'b1;
    @(negedge clk);
    tick      = 1'b0;
  endtask

  task automatic noise_tick();
    tick_once(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/state"},        32'(state),        0);
    check({tag, "/freeze"},       32'(freeze),       1);
    check({tag, "/round_reset"},  32'(round_reset),  0);
    check({tag, "/round_no"},     32'(round_no),     0);
    check({tag, "/p1_rounds"},    32'(p1_rounds),    0);
    check({tag, "/p2_rounds"},    32'(p2_rounds),    0);
    check({tag, "/countdown"},    32'(countdown),    0);
    check({tag, "/time_left"},    32'(time_left),    0);
    check({tag, "/match_over"},   32'(match_over),   0);
    check({tag, "/match_winner"}, 32'(match_winner), 0);
  endtask

  task automatic check_cd_entry(input string tag);
    check({tag, "/state"},        32'(state),        1);
    check({tag, "/countdown"},    32'(countdown),    3);
    check({tag, "/round_no"},     32'(round_no),     32'(m_round));
    check({tag, "/p1_rounds"},    32'(p1_rounds),    32'(m_p1));
    check({tag, "/p2_rounds"},    32'(p2_rounds),    32'(m_p2));
    check({tag, "/round_reset"},  32'(round_reset),  1);
    check({tag, "/freeze"},       32'(freeze),       1);
    check({tag, "/match_over"},   32'(match_over),   0);
    check({tag, "/match_winner"}, 32'(match_winner), 0);
  endtask

  task automatic start_from_idle();
    tick_once(1'b1, 2'($urandom_range(0, 3)));
    m_p1 = 0; m_p2 = 0; m_round = 1; m_over = 1'b0;
    rr_exp++;
    check_cd_entry("start");
  endtask

  // Digits step 3 -> 2 -> 1 every 20 ticks; the fight opens on tick 60.
  task automatic run_countdown();
    for (int k = 1; k <= 60; k++) begin
      noise_tick();
      if (k == 20) check("cd_digit2", 32'(countdown), 2);
      if (k == 40) check("cd_digit1", 32'(countdown), 1);
      if (k == 59) check("cd_still_cd", 32'(state), 1);
    end
    check("fight/state",     32'(state),     2);
    check("fight/countdown", 32'(countdown), 0);
    check("fight/time_left", 32'(time_left), 99);
    check("fight/freeze",    32'(freeze),    0);
    check("fight/rr_count",  32'(rr_cycles), 32'(rr_exp));
  endtask

  // n_clean quiet ticks, then one tick carrying res (00 only at the 1980th tick = timeout).
  task automatic run_fight(input int n_clean, input logic [1:0] res);
    for (int k = 0; k < n_clean; k++) tick_once(1'($urandom_range(0, 1)), 2'b00);
    check("fight_run/state",     32'(state),     2);
    check("fight_run/time_left", 32'(time_left), 32'(99 - n_clean / 20));
    tick_once(1'($urandom_range(0, 1)), res);
    m_res = (res == 2'b00) ? 2'b11 : res;
    check("ko/state",  32'(state),  3);
    check("ko/freeze", 32'(freeze), 1);
  endtask

  task automatic run_ko();
    for (int k = 1; k < 40; k++) noise_tick();
    check("ko_hold/state", 32'(state),     3);
    check("ko_hold/p1",    32'(p1_rounds), 32'(m_p1));
    check("ko_hold/p2",    32'(p2_rounds), 32'(m_p2));
    noise_tick();
    if (m_res == 2'b01) m_p1++;
    if (m_res == 2'b10) m_p2++;
    m_over = (m_p1 == 2) || (m_p2 == 2) || (m_round == 3);
    if (m_over) begin
      check("over/state",        32'(state),        4);
      check("over/match_over",   32'(match_over),   1);
      check("over/match_winner", 32'(match_winner),
            (m_p1 > m_p2) ? 1 : ((m_p2 > m_p1) ? 2 : 3));
      check("over/p1",           32'(p1_rounds),    32'(m_p1));
      check("over/p2",           32'(p2_rounds),    32'(m_p2));
      check("over/round_no",     32'(round_no),     32'(m_round));
      check("over/freeze",       32'(freeze),       1);
    end else begin
      m_round++;
      rr_exp++;
      check_cd_entry("next_round");
    end
  endtask

  task automatic play_round(input int n_clean, input logic [1:0] res);
    run_countdown();
    run_fight(n_clean, res);
    run_ko();
  endtask

  // 39 held, 1 released, 39 held must not restart; the 40th consecutive held tick does.
  task automatic restart_hold();
    for (int k = 0; k < 39; k++) tick_once(1'b1, 2'($urandom_range(0, 3)));
    tick_once(1'b0, 2'($urandom_range(0, 3)));
    for (int k = 0; k < 39; k++) tick_once(1'b1, 2'($urandom_range(0, 3)));
    check("hold39/state",      32'(state),      4);
    check("hold39/match_over", 32'(match_over), 1);
    tick_once(1'b1, 2'($urandom_range(0, 3)));
    m_p1 = 0; m_p2 = 0; m_round = 1; m_over = 1'b0;
    rr_exp++;
    check_cd_entry("restart");
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; start_btn = 1'b0; winner = 2'b00;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;
    for (int k = 0; k < 5; k++) tick_once(1'b0, 2'($urandom_range(0, 3)));
    check_reset_vals("idle_wait");

    // Match A: P1 takes rounds 1 and 2.
    start_from_idle();
    play_round(20, 2'b01);
    play_round($urandom_range(21, 300), 2'b01);
    restart_hold();

    // Match B: P1, P2, then a pure timeout -> 1-1 draw.
    play_round($urandom_range(0, 200), 2'b01);
    play_round($urandom_range(0, 200), 2'b10);
    play_round(1979, 2'b00);
    restart_hold();

    // Match C: winner=10 on the tick the clock hits 0 beats the timeout draw.
    play_round($urandom_range(0, 200), 2'b10);
    play_round($urandom_range(0, 200), 2'b01);
    play_round(1979, 2'b10);

    // Randomized matches, including drawn rounds.
    for (int m = 0; m < 4; m++) begin
      logic [1:0] res;
      restart_hold();
      while (!m_over) begin
        case ($urandom_range(0, 2))
          0:       res = 2'b01;
          1:       res = 2'b10;
          default: res = 2'b11;
        endcase
        play_round($urandom_range(0, 200), res);
      end
    end

    // Asynchronous reset in the middle of KO.
    restart_hold();
    run_countdown();
    run_fight($urandom_range(0, 50), 2'b01);
    for (int k = 0; k < 17; k++) noise_tick();
    #2 reset = 1'b1;
    #1 check_reset_vals("ko_reset");
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) tick_once(1'b0, 2'($urandom_range(0, 3)));
    check_reset_vals("after_ko_reset");

    // Reset while a round_reset pulse is in flight.
    start_from_idle();
    #1 reset = 1'b1;
    #1 check_reset_vals("rr_inflight");
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    check("final/rr_count", 32'(rr_cycles), 32'(rr_exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
